// File: rtl/adder_pipe_pkg.sv
// Shared helpers for the pipelined adder: chunk width and configuration legality.
package adder_pipe_pkg;

    function automatic int unsigned chunk_w(input int unsigned n, input int unsigned stages);
        return n / stages;
    endfunction

    // N must split into STAGES equal, non-empty chunks
    function automatic bit cfg_ok(input int unsigned n, input int unsigned stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_nb_if.sv
// Operand/result handshake bundle for adder_pipe_nb.
// ovf exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_pipe_nb_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_PIPE_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_PIPE_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/adder_pipe_stage.sv
// One W-bit chunk of the carry chain: registered sum, carry-out and stage valid.
module adder_pipe_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic         valid_o,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    logic [W:0]   add_d;
    logic         valid_q;
    logic [W-1:0] sum_q;
    logic         carry_q;

    always_comb begin
        add_d = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(carry_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= add_d[W-1:0];
            carry_q <= add_d[W];
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe_nb.sv
// adder_pipe_nb: STAGES-deep pipelined N-bit adder, one chunk per stage, global stall.
// Build option ADDER_PIPE_OVF_EN adds the signed-overflow flag aligned with sum.
module adder_pipe_nb
    import adder_pipe_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 4
) (
    input logic            clk,
    input logic            rst,
    adder_pipe_nb_if.slave bus
);
    localparam int unsigned W = chunk_w(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_cfg_err
        $error("adder_pipe_nb: N must be a multiple of STAGES with 1 <= STAGES <= N");
    end

    logic              en_c;
    logic [STAGES:0]   valid_w;
    logic [STAGES:0]   carry_w;
    logic [W-1:0]      a_chunk   [STAGES];
    logic [W-1:0]      b_chunk   [STAGES];
    logic [W-1:0]      sum_chunk [STAGES];
    logic [N-1:0]      sum_c;

    // Whole pipe holds while a result waits at the output
    assign en_c         = !(valid_w[STAGES] && !bus.out_ready);
    assign bus.in_ready = en_c;

    assign valid_w[0] = bus.in_valid;
    assign carry_w[0] = bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        localparam int unsigned D = STAGES - 1 - k;

        // Chunk k waits k cycles so it meets the carry of its own transaction
        if (k == 0) begin : g_direct
            assign a_chunk[k] = bus.a[W-1:0];
            assign b_chunk[k] = bus.b[W-1:0];
        end else begin : g_skew
            logic [W-1:0] a_q [k];
            logic [W-1:0] b_q [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < k; d++) begin
                        a_q[d] <= '0;
                        b_q[d] <= '0;
                    end
                end else if (en_c) begin
                    a_q[0] <= bus.a[k*W +: W];
                    b_q[0] <= bus.b[k*W +: W];
                    for (int d = 1; d < k; d++) begin
                        a_q[d] <= a_q[d-1];
                        b_q[d] <= b_q[d-1];
                    end
                end
            end

            assign a_chunk[k] = a_q[k-1];
            assign b_chunk[k] = b_q[k-1];
        end

        adder_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en_c),
            .valid_i (valid_w[k]),
            .a_i     (a_chunk[k]),
            .b_i     (b_chunk[k]),
            .carry_i (carry_w[k]),
            .valid_o (valid_w[k+1]),
            .sum_o   (sum_chunk[k]),
            .carry_o (carry_w[k+1])
        );

        // Early chunks wait for the last chunk so the full sum emerges together
        if (D == 0) begin : g_nodeskew
            assign sum_c[k*W +: W] = sum_chunk[k];
        end else begin : g_deskew
            logic [W-1:0] s_q [D];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < int'(D); d++) begin
                        s_q[d] <= '0;
                    end
                end else if (en_c) begin
                    s_q[0] <= sum_chunk[k];
                    for (int d = 1; d < int'(D); d++) begin
                        s_q[d] <= s_q[d-1];
                    end
                end
            end

            assign sum_c[k*W +: W] = s_q[D-1];
        end
    end

    assign bus.out_valid = valid_w[STAGES];
    assign bus.sum       = sum_c;
    assign bus.cout      = carry_w[STAGES];

`ifdef ADDER_PIPE_OVF_EN
    // Operand MSBs captured beside the last stage, so they align with its sum
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (en_c) begin
            a_msb_q <= a_chunk[STAGES-1][W-1];
            b_msb_q <= b_chunk[STAGES-1][W-1];
        end
    end

    assign bus.ovf = (a_msb_q == b_msb_q) && (sum_c[N-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_adder_pipe_nb.sv
// Self-checking bench for adder_pipe_nb: N=16/STAGES=4 main instance plus 8/1 and 8/8 builds.
module tb_adder_pipe_nb;
    localparam int unsigned N      = 16;
    localparam int unsigned STAGES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_pipe_nb_if #(.N(16)) bus  ();
    adder_pipe_nb_if #(.N(8))  bus1 ();
    adder_pipe_nb_if #(.N(8))  bus8 ();

    adder_pipe_nb #(.N(16), .STAGES(4)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    adder_pipe_nb #(.N(8),  .STAGES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    adder_pipe_nb #(.N(8),  .STAGES(8)) dut_s8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q [$];

    // {ovf, cout, sum} straight from the arithmetic definition
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        t = 17'(a) + 17'(b) + 17'(cin);
        return {(a[15] == b[15]) && (t[15] != a[15]), t};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0; bus.out_ready  = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if ({bus.cout, bus.sum} !== 17'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", {bus.cout, bus.sum}); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++;
        if ({bus1.out_valid, bus8.out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_degenerate_valid: got %b expected 00", {bus1.out_valid, bus8.out_valid}); end
`ifdef ADDER_PIPE_OVF_EN
        n_checks++;
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
        bus.out_ready = 1'b1;
    endtask

    task automatic test_carry_ripple();
        logic [17:0] e;
        e = model(16'hFFFF, 16'h0001, 1'b0);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ripple_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        idle_inputs();
        for (int c = 1; c <= int'(STAGES) + 1; c++) begin
            n_checks++;
            if (bus.out_valid !== (c == int'(STAGES))) begin
                n_fail++; $display("FAIL ripple_valid cycle %0d: got %b expected %b", c, bus.out_valid, c == int'(STAGES));
            end
            if (c == int'(STAGES)) begin
                n_checks++;
                if ({bus.cout, bus.sum} !== e[16:0]) begin n_fail++; $display("FAIL ripple_result: got %h expected %h", {bus.cout, bus.sum}, e[16:0]); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        bit exp_v;
        exp_q.delete();
        for (int c = 0; c < 8 + int'(STAGES) + 2; c++) begin
            exp_v = (c >= int'(STAGES)) && (c < int'(STAGES) + 8);
            n_checks++;
            if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid cycle %0d: got %b expected %b", c, bus.out_valid, exp_v); end
            if (exp_v && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.cout, bus.sum} !== e[16:0]) begin n_fail++; $display("FAIL b2b_result cycle %0d: got %h expected %h", c, {bus.cout, bus.sum}, e[16:0]); end
            end
            if (c < 8) begin
                bus.a = 16'(c * 16'h1111); bus.b = 16'h0F0F; bus.cin = c[0]; bus.in_valid = 1'b1;
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
            end else begin
                idle_inputs();
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [17:0] e;
        logic [16:0] held;
        bit ivld, ordy, prev_stall;
        int n_in, n_out;
        exp_q.delete();
        prev_stall = 1'b0; held = '0; n_in = 0; n_out = 0;
        for (int c = 0; c < 30; c++) begin
            ordy = !((c >= int'(STAGES)) && (c < int'(STAGES) + 3));
            ivld = (c < 3) || ((c >= int'(STAGES)) && (c <= int'(STAGES) + 3));
            bus.out_ready = ordy; bus.in_valid = ivld;
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
            #1;
            n_checks++;
            if (bus.in_ready !== !(bus.out_valid && !ordy)) begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b expected %b", c, bus.in_ready, !(bus.out_valid && !ordy)); end
            if (prev_stall) begin
                n_checks++;
                if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, held}) begin n_fail++; $display("FAIL stall_hold cycle %0d: got %h expected %h", c, {bus.out_valid, bus.cout, bus.sum}, {1'b1, held}); end
            end
            if (bus.out_valid && ordy) begin
                n_out++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3FFFF;
                n_checks++;
                if ({bus.cout, bus.sum} !== e[16:0]) begin n_fail++; $display("FAIL stall_result cycle %0d: got %h expected %h", c, {bus.cout, bus.sum}, e[16:0]); end
            end
            if (ivld && bus.in_ready) begin
                n_in++;
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
            end
            prev_stall = bus.out_valid && !ordy;
            held = {bus.cout, bus.sum};
            tick();
        end
        idle_inputs();
        n_checks++;
        if (n_in != 4 || n_out != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stall_count: got in=%0d out=%0d left=%0d expected 4 4 0", n_in, n_out, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [17:0] e;
        for (int c = 0; c < 3; c++) begin
            bus.a = pick(); bus.b = pick(); bus.cin = 1'($urandom); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            tick();
        end
        rst = 1'b1;
        bus.a = 16'h1234; bus.b = 16'h4321;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < int'(STAGES) + 3; c++) begin
            n_checks++;
            if ({bus.out_valid, bus.cout, bus.sum} !== 18'h0) begin
                n_fail++; $display("FAIL midflight_flush cycle %0d: got %h expected 0", c, {bus.out_valid, bus.cout, bus.sum});
            end
            tick();
        end
        e = model(16'hA5A5, 16'h5A5B, 1'b1);
        bus.a = 16'hA5A5; bus.b = 16'h5A5B; bus.cin = 1'b1; bus.in_valid = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c < int'(STAGES); c++) tick();
        n_checks++;
        if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, e[16:0]}) begin
            n_fail++; $display("FAIL midflight_new: got %h expected %h", {bus.out_valid, bus.cout, bus.sum}, {1'b1, e[16:0]});
        end
        tick();
    endtask

`ifdef ADDER_PIPE_OVF_EN
    task automatic test_overflow();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [17:0] want [2];
        va[0] = 16'h7FFF; vb[0] = 16'h0001; want[0] = {1'b1, 1'b0, 16'h8000};
        va[1] = 16'h8000; vb[1] = 16'h8000; want[1] = {1'b1, 1'b1, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            bus.a = va[v]; bus.b = vb[v]; bus.cin = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            tick();
            idle_inputs();
            for (int c = 1; c < int'(STAGES); c++) tick();
            n_checks++;
            if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== {1'b1, want[v]}) begin
                n_fail++; $display("FAIL overflow_%0d: got %h expected %h", v, {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, want[v]});
            end
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [17:0] e;
        logic [16:0] held;
        bit ivld, ordy, prev_stall, draining;
        exp_q.delete();
        prev_stall = 1'b0; held = '0;
        for (int c = 0; c < 120; c++) begin
            draining = (c >= 70);
            if (draining && exp_q.size() == 0 && !bus.out_valid) break;
            ivld = !draining && ($urandom_range(0, 3) != 0);
            ordy = draining || ($urandom_range(0, 3) != 0);
            bus.in_valid = ivld; bus.out_ready = ordy;
            bus.a = pick(); bus.b = pick(); bus.cin = 1'($urandom);
            #1;
            n_checks++;
            if (bus.in_ready !== !(bus.out_valid && !ordy)) begin n_fail++; $display("FAIL rand_in_ready cycle %0d: got %b expected %b", c, bus.in_ready, !(bus.out_valid && !ordy)); end
            if (prev_stall) begin
                n_checks++;
                if ({bus.out_valid, bus.cout, bus.sum} !== {1'b1, held}) begin n_fail++; $display("FAIL rand_hold cycle %0d: got %h expected %h", c, {bus.out_valid, bus.cout, bus.sum}, {1'b1, held}); end
            end
            if (bus.out_valid && ordy) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3FFFF;
                n_checks++;
                if ({bus.cout, bus.sum} !== e[16:0]) begin n_fail++; $display("FAIL rand_result cycle %0d: got %h expected %h", c, {bus.cout, bus.sum}, e[16:0]); end
`ifdef ADDER_PIPE_OVF_EN
                n_checks++;
                if (bus.ovf !== e[17]) begin n_fail++; $display("FAIL rand_ovf cycle %0d: got %b expected %b", c, bus.ovf, e[17]); end
`endif
            end
            if (ivld && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin));
            prev_stall = bus.out_valid && !ordy;
            held = {bus.cout, bus.sum};
            tick();
        end
        idle_inputs();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_degenerate();
        logic [8:0] e;
        e = 9'(8'hFF) + 9'(8'hFF) + 9'(1'b1);
        bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.cin = 1'b1; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c <= 9; c++) begin
            n_checks++;
            if (bus1.out_valid !== (c == 1)) begin n_fail++; $display("FAIL s1_valid cycle %0d: got %b expected %b", c, bus1.out_valid, c == 1); end
            n_checks++;
            if (bus8.out_valid !== (c == 8)) begin n_fail++; $display("FAIL s8_valid cycle %0d: got %b expected %b", c, bus8.out_valid, c == 8); end
            if (c == 1) begin
                n_checks++;
                if ({bus1.cout, bus1.sum} !== e) begin n_fail++; $display("FAIL s1_result: got %h expected %h", {bus1.cout, bus1.sum}, e); end
            end
            if (c == 8) begin
                n_checks++;
                if ({bus8.cout, bus8.sum} !== e) begin n_fail++; $display("FAIL s8_result: got %h expected %h", {bus8.cout, bus8.sum}, e); end
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_carry_ripple();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef ADDER_PIPE_OVF_EN
        test_overflow();
`endif
        test_random();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
